axis_packet_checker: RTL and testbench

AXIS_PACKET_CHECKER -- requirements
Module: axis_packet_checker

---
 rtl/axis_packet_checker.sv | 210 +++++++++++++++++++++
 tb/tb_axis_packet_checker.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_packet_checker.sv
// AXI-Stream packet checker with an AXI-Lite register bank.
// Incoming packets are expected to carry an incrementing beat index as data
// and to be EXP_LEN beats long. Received and erroneous packets are counted,
// and the checker can stop itself after EXP_COUNT packets.
module axis_packet_checker #(
  parameter int C_S0_AXI_DATA_WIDTH   = 32,
  parameter int C_S0_AXI_ADDR_WIDTH   = 5,
  parameter int C_S0_AXIS_TDATA_WIDTH = 32
) (
  input  logic                               s0_axi_aclk,
  input  logic                               s0_axi_areset,
  input  logic [C_S0_AXI_ADDR_WIDTH-1:0]     s0_axi_awaddr,
  input  logic [2:0]                         s0_axi_awprot,
  input  logic                               s0_axi_awvalid,
  output logic                               s0_axi_awready,
  input  logic [C_S0_AXI_DATA_WIDTH-1:0]     s0_axi_wdata,
  input  logic [C_S0_AXI_DATA_WIDTH/8-1:0]   s0_axi_wstrb,
  input  logic                               s0_axi_wvalid,
  output logic                               s0_axi_wready,
  output logic [1:0]                         s0_axi_bresp,
  output logic                               s0_axi_bvalid,
  input  logic                               s0_axi_bready,
  input  logic [C_S0_AXI_ADDR_WIDTH-1:0]     s0_axi_araddr,
  input  logic [2:0]                         s0_axi_arprot,
  input  logic                               s0_axi_arvalid,
  output logic                               s0_axi_arready,
  output logic [C_S0_AXI_DATA_WIDTH-1:0]     s0_axi_rdata,
  output logic [1:0]                         s0_axi_rresp,
  output logic                               s0_axi_rvalid,
  input  logic                               s0_axi_rready,
  input  logic                               s0_axis_tvalid,
  input  logic [C_S0_AXIS_TDATA_WIDTH-1:0]   s0_axis_tdata,
  input  logic                               s0_axis_tlast,
  output logic                               s0_axis_tready
);

  localparam int DW = C_S0_AXI_DATA_WIDTH;
  localparam int TW = C_S0_AXIS_TDATA_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic          aw_rdy, ar_rdy, tready_r;
  logic          enable, done, err_sticky, pkt_err;
  logic [DW-1:0] exp_len, exp_count, pkt_rcvd, err_count, rd_mux;
  logic [31:0]   beat_idx;
  logic [2:0]    wr_idx, rd_idx;
  logic          wr_en, rd_en, clear;
  logic          beat, last_beat, mism, over, len_bad, pkt_bad;
  logic [DW-1:0] pkt_rcvd_inc, err_count_inc;
  logic          unused_bits;

  // Byte-lane merge of a register write.
  function automatic logic [DW-1:0] wstrb_merge(input logic [DW-1:0] old,
                                                input logic [DW-1:0] d,
                                                input logic [DW/8-1:0] s);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < DW/8; b++) begin
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    end
    return r;
  endfunction

  assign wr_idx = s0_axi_awaddr[4:2];
  assign rd_idx = s0_axi_araddr[4:2];
  assign wr_en  = aw_rdy & s0_axi_awvalid & s0_axi_wvalid;
  assign rd_en  = ar_rdy & s0_axi_arvalid;
  assign clear  = wr_en && (wr_idx == 3'd0) && s0_axi_wstrb[0] && s0_axi_wdata[1];

  assign s0_axi_awready = aw_rdy;
  assign s0_axi_wready  = aw_rdy;
  assign s0_axi_arready = ar_rdy;
  assign s0_axi_bresp   = 2'b00;
  assign s0_axi_rresp   = 2'b00;
  assign s0_axis_tready = tready_r;

  // Beat classification; a packet is bad if any beat so far was bad.
  assign beat          = s0_axis_tvalid & tready_r;
  assign last_beat     = beat & s0_axis_tlast;
  assign mism          = s0_axis_tdata != TW'(beat_idx);
  assign over          = !s0_axis_tlast && (beat_idx >= exp_len);
  assign len_bad       = s0_axis_tlast && ((beat_idx + 32'd1) != exp_len);
  assign pkt_bad       = pkt_err | mism | over | len_bad;
  assign pkt_rcvd_inc  = (pkt_rcvd == '1) ? pkt_rcvd : pkt_rcvd + 1'b1;
  assign err_count_inc = (err_count == '1) ? err_count : err_count + 1'b1;

  assign unused_bits = ^{s0_axi_awprot, s0_axi_arprot,
                         s0_axi_awaddr[1:0], s0_axi_araddr[1:0]};

  // Next-state logic: stop on reaching a non-zero expected packet count.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (enable) state_nxt = RUN;
      RUN: begin
        if (!enable || clear)
          state_nxt = IDLE;
        else if (last_beat && (exp_count != '0) && (pkt_rcvd_inc >= exp_count))
          state_nxt = DONE;
      end
      DONE: if (!enable || clear) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; tready is registered from the next state.
  always_ff @(posedge s0_axi_aclk) begin
    if (s0_axi_areset) begin
      state    <= IDLE;
      tready_r <= 1'b0;
    end else begin
      state    <= state_nxt;
      tready_r <= (state_nxt == RUN);
    end
  end

  // Writable configuration registers with byte-lane strobes.
  always_ff @(posedge s0_axi_aclk) begin
    if (s0_axi_areset) begin
      enable    <= 1'b0;
      exp_len   <= '0;
      exp_count <= '0;
    end else if (wr_en) begin
      case (wr_idx)
        3'd0: if (s0_axi_wstrb[0]) enable <= s0_axi_wdata[0];
        3'd1: exp_len   <= wstrb_merge(exp_len, s0_axi_wdata, s0_axi_wstrb);
        3'd2: exp_count <= wstrb_merge(exp_count, s0_axi_wdata, s0_axi_wstrb);
        default: ;
      endcase
    end
  end

  // Packet tracking, counters and status; clear beats a coincident tlast.
  always_ff @(posedge s0_axi_aclk) begin
    if (s0_axi_areset || clear) begin
      pkt_rcvd   <= '0;
      err_count  <= '0;
      done       <= 1'b0;
      err_sticky <= 1'b0;
      beat_idx   <= '0;
      pkt_err    <= 1'b0;
    end else begin
      if (last_beat) begin
        pkt_rcvd <= pkt_rcvd_inc;
        if (pkt_bad) begin
          err_count  <= err_count_inc;
          err_sticky <= 1'b1;
        end
      end
      if (state_nxt != RUN) begin
        beat_idx <= '0;
        pkt_err  <= 1'b0;
      end else if (beat) begin
        beat_idx <= s0_axis_tlast ? '0 : beat_idx + 32'd1;
        pkt_err  <= s0_axis_tlast ? 1'b0 : pkt_bad;
      end
      if (!enable)
        done <= 1'b0;
      else if ((state != DONE) && (state_nxt == DONE))
        done <= 1'b1;
    end
  end

  // Write channel: one-cycle ready pulse, response held until accepted.
  always_ff @(posedge s0_axi_aclk) begin
    if (s0_axi_areset) begin
      aw_rdy        <= 1'b0;
      s0_axi_bvalid <= 1'b0;
    end else begin
      aw_rdy <= s0_axi_awvalid & s0_axi_wvalid & !s0_axi_bvalid & !aw_rdy;
      if (wr_en)
        s0_axi_bvalid <= 1'b1;
      else if (s0_axi_bready)
        s0_axi_bvalid <= 1'b0;
    end
  end

  // Read data mux; counters are read as they stood before this edge.
  always_comb begin
    rd_mux = '0;
    case (rd_idx)
      3'd0: rd_mux = {{(DW-1){1'b0}}, enable};
      3'd1: rd_mux = exp_len;
      3'd2: rd_mux = exp_count;
      3'd3: rd_mux = pkt_rcvd;
      3'd4: rd_mux = err_count;
      3'd5: rd_mux = {{(DW-2){1'b0}}, err_sticky, done};
      default: rd_mux = '0;
    endcase
  end

  // Read channel: one-cycle ready pulse, data held until accepted.
  always_ff @(posedge s0_axi_aclk) begin
    if (s0_axi_areset) begin
      ar_rdy        <= 1'b0;
      s0_axi_rvalid <= 1'b0;
      s0_axi_rdata  <= '0;
    end else begin
      ar_rdy <= s0_axi_arvalid & !s0_axi_rvalid & !ar_rdy;
      if (rd_en) begin
        s0_axi_rvalid <= 1'b1;
        s0_axi_rdata  <= rd_mux;
      end else if (s0_axi_rready) begin
        s0_axi_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_packet_checker.sv
// Bench for axis_packet_checker: AXI-Lite register access and stream checks.
module tb_axis_packet_checker;

  localparam int BUDGET = 200;

  logic        clk = 1'b0;
  logic        areset;
  logic [4:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] wdata, rdata, tdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready;
  logic        tvalid, tlast, tready;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  axis_packet_checker dut (
    .s0_axi_aclk(clk), .s0_axi_areset(areset),
    .s0_axi_awaddr(awaddr), .s0_axi_awprot(awprot), .s0_axi_awvalid(awvalid),
    .s0_axi_awready(awready),
    .s0_axi_wdata(wdata), .s0_axi_wstrb(wstrb), .s0_axi_wvalid(wvalid),
    .s0_axi_wready(wready),
    .s0_axi_bresp(bresp), .s0_axi_bvalid(bvalid), .s0_axi_bready(bready),
    .s0_axi_araddr(araddr), .s0_axi_arprot(arprot), .s0_axi_arvalid(arvalid),
    .s0_axi_arready(arready),
    .s0_axi_rdata(rdata), .s0_axi_rresp(rresp), .s0_axi_rvalid(rvalid),
    .s0_axi_rready(rready),
    .s0_axis_tvalid(tvalid), .s0_axis_tdata(tdata), .s0_axis_tlast(tlast),
    .s0_axis_tready(tready)
  );

  always #5 clk = ~clk;

  task automatic axi_write(input logic [2:0] idx, input logic [31:0] data,
                           input logic [3:0] strb, input int hold);
    int n;
    awaddr = {idx, 2'b00}; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!(awready && wready) && n < BUDGET);
    checks++;
    if (!(awready && wready)) begin
      errors++; $display("FAIL wr_handshake idx=%0d awready=%0b wready=%0b required 1", idx, awready, wready);
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    checks++;
    if (bvalid !== 1'b1) begin
      errors++; $display("FAIL bvalid_rise got=%0b required 1", bvalid);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bvalid !== 1'b1) begin
        errors++; $display("FAIL bvalid_hold cycle=%0d got=%0b required 1", i, bvalid);
      end
    end
    checks++;
    if (bresp !== 2'b00) begin
      errors++; $display("FAIL bresp got=%0d required 0", bresp);
    end
    bready = 1'b1; @(posedge clk); #1; bready = 1'b0;
    checks++;
    if (bvalid !== 1'b0) begin
      errors++; $display("FAIL bvalid_drop got=%0b required 0", bvalid);
    end
  endtask

  task automatic axi_read(input logic [2:0] idx, input string name, input int hold);
    int n;
    logic [31:0] exp, first;
    araddr = {idx, 2'b00}; arvalid = 1'b1; rready = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < BUDGET);
    checks++;
    if (!arready) begin
      errors++; $display("FAIL rd_handshake idx=%0d arready=%0b required 1", idx, arready);
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    checks++;
    if (rvalid !== 1'b1) begin
      errors++; $display("FAIL rvalid_rise got=%0b required 1", rvalid);
    end
    first = rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rvalid !== 1'b1 || rdata !== first) begin
        errors++; $display("FAIL rd_hold rvalid=%0b rdata=%h required 1/%h", rvalid, rdata, first);
      end
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL %s no expected value queued", name);
    end else begin
      exp = exp_q.pop_front();
      if (rdata !== exp) begin
        errors++; $display("FAIL %s got=%h required %h", name, rdata, exp);
      end
    end
    checks++;
    if (rresp !== 2'b00) begin
      errors++; $display("FAIL rresp got=%0d required 0", rresp);
    end
    rready = 1'b1; @(posedge clk); #1; rready = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] data, input logic last);
    int n, g;
    g = $urandom_range(0, 2);
    for (int i = 0; i < g; i++) begin @(posedge clk); #1; end
    tvalid = 1'b1; tdata = data; tlast = last;
    n = 0;
    do begin @(negedge clk); n++; end while (!tready && n < BUDGET);
    checks++;
    if (!tready) begin
      errors++; $display("FAIL beat_accept data=%h tready=%0b required 1", data, tready);
    end
    @(posedge clk); #1;
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic send_pkt(input int len, input int bad_beat, input logic [31:0] bad_val);
    for (int i = 0; i < len; i++)
      send_beat((i == bad_beat) ? bad_val : 32'(i), i == len - 1);
  endtask

  task automatic test_reset;
    areset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({awready, wready, bvalid, arready, rvalid, tready} !== 6'b0) begin
      errors++; $display("FAIL reset_handshake got=%b required 000000",
                         {awready, wready, bvalid, arready, rvalid, tready});
    end
    checks++;
    if (rdata !== 32'd0 || bresp !== 2'd0 || rresp !== 2'd0) begin
      errors++; $display("FAIL reset_data rdata=%h bresp=%0d rresp=%0d required 0", rdata, bresp, rresp);
    end
    areset = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(32'd0);
      axi_read(3'(i), "reset_reg", 0);
    end
  endtask

  task automatic test_basic;
    axi_write(3'd1, 32'd9, 4'hF, 0);
    axi_write(3'd2, 32'd4, 4'hF, 0);
    axi_write(3'd0, 32'd1, 4'hF, 0);
    for (int p = 0; p < 4; p++) send_pkt(9, -1, 32'd0);
    checks++;
    if (tready !== 1'b0) begin
      errors++; $display("FAIL basic_tready_done got=%0b required 0", tready);
    end
    exp_q.push_back(32'd4); axi_read(3'd3, "basic_pkt_rcvd", 0);
    exp_q.push_back(32'd0); axi_read(3'd4, "basic_err_count", 0);
    exp_q.push_back(32'd1); axi_read(3'd5, "basic_status", 0);
  endtask

  task automatic test_bad_data;
    axi_write(3'd0, 32'd2, 4'hF, 0);
    exp_q.push_back(32'd0); axi_read(3'd5, "clear_status", 0);
    axi_write(3'd0, 32'd1, 4'hF, 0);
    for (int p = 0; p < 4; p++) send_pkt(9, (p == 1) ? 5 : -1, 32'hDEAD);
    exp_q.push_back(32'd4); axi_read(3'd3, "bad_pkt_rcvd", 0);
    exp_q.push_back(32'd1); axi_read(3'd4, "bad_err_count", 0);
    exp_q.push_back(32'd3); axi_read(3'd5, "bad_status", 0);
  endtask

  task automatic test_length;
    axi_write(3'd0, 32'd2, 4'hF, 0);
    axi_write(3'd2, 32'd0, 4'hF, 0);
    axi_write(3'd0, 32'd1, 4'hF, 0);
    send_pkt(8, -1, 32'd0);
    send_pkt(11, -1, 32'd0);
    exp_q.push_back(32'd2); axi_read(3'd3, "len_pkt_rcvd", 0);
    exp_q.push_back(32'd2); axi_read(3'd4, "len_err_count", 0);
    exp_q.push_back(32'd2); axi_read(3'd5, "len_status", 0);
    checks++;
    if (tready !== 1'b1) begin
      errors++; $display("FAIL unlimited_tready got=%0b required 1", tready);
    end
    send_pkt(9, -1, 32'd0);
    exp_q.push_back(32'd3); axi_read(3'd3, "unlimited_pkt_rcvd", 0);
    exp_q.push_back(32'd2); axi_read(3'd4, "unlimited_err_count", 0);
  endtask

  task automatic test_abort;
    axi_write(3'd0, 32'd2, 4'hF, 0);
    axi_write(3'd0, 32'd1, 4'hF, 0);
    for (int i = 0; i < 4; i++) send_beat(32'(i), 1'b0);
    axi_write(3'd0, 32'd0, 4'hF, 0);
    checks++;
    if (tready !== 1'b0) begin
      errors++; $display("FAIL abort_tready got=%0b required 0", tready);
    end
    exp_q.push_back(32'd0); axi_read(3'd3, "abort_pkt_rcvd_partial", 0);
    axi_write(3'd0, 32'd1, 4'hF, 0);
    send_pkt(9, -1, 32'd0);
    exp_q.push_back(32'd1); axi_read(3'd3, "abort_pkt_rcvd", 0);
    exp_q.push_back(32'd0); axi_read(3'd4, "abort_err_count", 0);
  endtask

  task automatic test_regs;
    axi_write(3'd3, 32'h55, 4'hF, 5);
    exp_q.push_back(32'd1); axi_read(3'd3, "ro_pkt_rcvd", 5);
    exp_q.push_back(32'd0); axi_read(3'd7, "unmapped_7", 5);
    exp_q.push_back(32'd0); axi_read(3'd6, "unmapped_6", 0);
    exp_q.push_back(32'd1); axi_read(3'd0, "ctrl_enable", 0);
    axi_write(3'd1, 32'h12345678, 4'b0101, 0);
    exp_q.push_back(32'h00340078); axi_read(3'd1, "exp_len_strb", 0);
    axi_write(3'd1, 32'd9, 4'hF, 0);
    axi_write(3'd0, 32'd3, 4'hF, 0);
    exp_q.push_back(32'd1); axi_read(3'd0, "ctrl_clear_reads0", 0);
    exp_q.push_back(32'd0); axi_read(3'd3, "clear_pkt_rcvd", 0);
  endtask

  task automatic test_reset_mid;
    int n, seen;
    for (int i = 0; i < 3; i++) send_beat(32'(i), 1'b0);
    tvalid = 1'b1; tdata = 32'd3; tlast = 1'b0;
    awaddr = {3'd1, 2'b00}; wdata = 32'h77; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < BUDGET);
    checks++;
    if (!awready) begin
      errors++; $display("FAIL midrst_aw awready=%0b required 1", awready);
    end
    areset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({awready, wready, bvalid, arready, rvalid, tready} !== 6'b0 || rdata !== 32'd0) begin
      errors++; $display("FAIL midrst_outputs got=%b rdata=%h required 000000/0",
                         {awready, wready, bvalid, arready, rvalid, tready}, rdata);
    end
    areset = 1'b0; awvalid = 1'b0; wvalid = 1'b0; tvalid = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bvalid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL midrst_bvalid cycles_high=%0d required 0", seen);
    end
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(32'd0);
      axi_read(3'(i), "midrst_reg", 0);
    end
  endtask

  initial begin
    areset = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    tvalid = 1'b0; tdata = '0; tlast = 1'b0;
    test_reset;
    test_basic;
    test_bad_data;
    test_length;
    test_abort;
    test_regs;
    axi_write(3'd0, 32'd1, 4'hF, 0);
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
